// File: rtl/sd_resp_rx.sv
// sd_resp_rx: SPI-mode SD response receiver (isStart/respLong/DO in; isBusy/isFinish/isTimeout/r1/payload out)
module sd_resp_rx #(
  parameter int TIMEOUT = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isStart,
  input  logic        respLong,
  input  logic        DO,
  output logic        isBusy,
  output logic        isFinish,
  output logic        isTimeout,
  output logic [7:0]  r1,
  output logic [31:0] payload
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, WAIT_START = 3'd1, R1_BITS = 3'd2, PAYLOAD = 3'd3, DONE = 3'd4;
  logic [2:0]    state_q, state_d;
  logic          long_q, long_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    r1_q, r1_d;
  logic [31:0]   payload_q, payload_d;
  logic          busy_q, busy_d;
  logic          finish_q, finish_d;
  logic          timeout_q, timeout_d;
  always_comb begin
    state_d = state_q;
    long_d = long_q;
    wait_cnt_d = wait_cnt_q;
    idx_d = idx_q;
    r1_d = r1_q;
    payload_d = payload_q;
    busy_d = busy_q;
    finish_d = finish_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (isStart) begin
        long_d = respLong;
        r1_d = 8'hFF;
        payload_d = '0;
        timeout_d = 1'b0;
        wait_cnt_d = '0;
        busy_d = 1'b1;
        state_d = WAIT_START;
      end
      WAIT_START: if (!DO) begin
        r1_d[7] = 1'b0;
        idx_d = 5'd6;
        state_d = R1_BITS;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          finish_d = 1'b1;
          state_d = DONE;
        end
      end
      R1_BITS: begin
        r1_d[idx_q[2:0]] = DO;
        idx_d = idx_q - 1'b1;
        // r1[2] was captured on an earlier edge; an illegal-command R1 has no trailer
        if (idx_q == 5'd0) begin
          if (long_q && !r1_q[2]) begin
            idx_d = 5'd31;
            state_d = PAYLOAD;
          end else begin
            finish_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      PAYLOAD: begin
        payload_d[idx_q] = DO;
        idx_d = idx_q - 1'b1;
        if (idx_q == 5'd0) begin
          finish_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (!isStart) begin
        busy_d = 1'b0;
        finish_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d = 1'b0;
        finish_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      long_q <= 1'b0;
      wait_cnt_q <= '0;
      idx_q <= '0;
      r1_q <= 8'hFF;
      payload_q <= '0;
      busy_q <= 1'b0;
      finish_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      long_q <= long_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q <= idx_d;
      r1_q <= r1_d;
      payload_q <= payload_d;
      busy_q <= busy_d;
      finish_q <= finish_d;
      timeout_q <= timeout_d;
    end
  end
  assign isBusy = busy_q;
  assign isFinish = finish_q;
  assign isTimeout = timeout_q;
  assign r1 = r1_q;
  assign payload = payload_q;
endmodule

// File: tb/tb_sd_resp_rx.sv
// tb_sd_resp_rx: directed self-checking bench for sd_resp_rx
module tb_sd_resp_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        isStart = 1'b0;
  logic        respLong = 1'b0;
  logic        DO = 1'b1;
  logic        isBusy, isFinish, isTimeout;
  logic [7:0]  r1;
  logic [31:0] payload;
  int checks = 0;
  int errors = 0;
  sd_resp_rx #(.TIMEOUT(80)) dut (
    .clk(clk), .rst(rst), .isStart(isStart), .respLong(respLong), .DO(DO),
    .isBusy(isBusy), .isFinish(isFinish), .isTimeout(isTimeout), .r1(r1), .payload(payload)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DO = v[i];
      @(negedge clk);
    end
  endtask
  task automatic start_req(input logic lng);
    isStart = 1'b1;
    respLong = lng;
    DO = 1'b1;
    @(negedge clk);
    chk("accept_busy", 32'(isBusy), 32'd1);
    chk("accept_fin", 32'(isFinish), 32'd0);
  endtask
  task automatic end_req();
    isStart = 1'b0;
    DO = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(isBusy), 32'd0);
    chk("idle_fin", 32'(isFinish), 32'd0);
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(isBusy), 32'd0);
    chk("rst_fin", 32'(isFinish), 32'd0);
    chk("rst_to", 32'(isTimeout), 32'd0);
    chk("rst_r1", 32'(r1), 32'hFF);
    chk("rst_pl", payload, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(isBusy), 32'd0);
    start_req(1'b0);
    send_bits({3'b111, 8'h01} >> 1, 10);
    chk("t1_early", 32'(isFinish), 32'd0);
    send_bits(64'd1, 1);
    chk("t1_fin", 32'(isFinish), 32'd1);
    chk("t1_r1", 32'(r1), 32'h01);
    chk("t1_to", 32'(isTimeout), 32'd0);
    chk("t1_pl", payload, 32'd0);
    end_req();
    start_req(1'b1);
    respLong = 1'b0;
    send_bits({2'b11, 8'h01, 32'h000001AA} >> 1, 41);
    chk("t2_early", 32'(isFinish), 32'd0);
    send_bits(64'd0, 1);
    chk("t2_fin", 32'(isFinish), 32'd1);
    chk("t2_r1", 32'(r1), 32'h01);
    chk("t2_pl", payload, 32'h000001AA);
    end_req();
    start_req(1'b1);
    send_bits({1'b1, 8'h05}, 9);
    chk("t3_fin", 32'(isFinish), 32'd1);
    chk("t3_r1", 32'(r1), 32'h05);
    chk("t3_pl", payload, 32'd0);
    send_bits(64'h00, 8);
    chk("t3_hold_r1", 32'(r1), 32'h05);
    chk("t3_hold_pl", payload, 32'd0);
    chk("t3_hold_fin", 32'(isFinish), 32'd1);
    end_req();
    start_req(1'b0);
    send_bits({64{1'b1}}, 79);
    chk("t4_early", 32'(isFinish), 32'd0);
    send_bits(64'd1, 1);
    chk("t4_fin", 32'(isFinish), 32'd1);
    chk("t4_to", 32'(isTimeout), 32'd1);
    chk("t4_r1", 32'(r1), 32'hFF);
    end_req();
    start_req(1'b0);
    send_bits({64{1'b1}}, 79);
    send_bits(64'h0, 1);
    chk("t4b_s80_fin", 32'(isFinish), 32'd0);
    send_bits(64'h3C, 7);
    chk("t4b_fin", 32'(isFinish), 32'd1);
    chk("t4b_to", 32'(isTimeout), 32'd0);
    chk("t4b_r1", 32'(r1), 32'h3C);
    for (int i = 0; i < 5; i++) begin
      DO = i[0];
      @(negedge clk);
      chk("t5_hold_fin", 32'(isFinish), 32'd1);
      chk("t5_hold_busy", 32'(isBusy), 32'd1);
      chk("t5_hold_r1", 32'(r1), 32'h3C);
    end
    end_req();
    start_req(1'b0);
    chk("t5_clr_r1", 32'(r1), 32'hFF);
    chk("t5_clr_to", 32'(isTimeout), 32'd0);
    send_bits(64'h00, 8);
    chk("t5_fin", 32'(isFinish), 32'd1);
    chk("t5_r1", 32'(r1), 32'h00);
    end_req();
    start_req(1'b1);
    send_bits({8'h01, 10'h3FF}, 18);
    chk("t6_pre_busy", 32'(isBusy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(isBusy), 32'd0);
    chk("t6_fin", 32'(isFinish), 32'd0);
    chk("t6_r1", 32'(r1), 32'hFF);
    chk("t6_pl", payload, 32'd0);
    chk("t6_to", 32'(isTimeout), 32'd0);
    isStart = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_req(1'b0);
    send_bits({1'b1, 8'h7E}, 9);
    chk("t6_re_fin", 32'(isFinish), 32'd1);
    chk("t6_re_r1", 32'(r1), 32'h7E);
    chk("t6_re_pl", payload, 32'd0);
    end_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
